freq_select_ctrl: RTL and testbench

//  Pushbutton front end for the throttle clock divider. Synchronises and debounces
//  the raw up/down buttons and runs a press/hold auto-repeat FSM. Drives a

---
 rtl/freq_select_if.sv | 33 +++
 rtl/freq_select_ctrl.sv | 157 +++++++++++++++
 tb/tb_freq_select_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_select_if.sv
// rtl/freq_select_if.sv - button/level bundle between board pins, selector and divider
//
// Purpose: groups the raw pushbutton inputs and the frequency-level outputs of
//          freq_select_ctrl so that both travel through a single port.
// Ports (signals):
//   pb_freq_up, pb_freq_dn  raw buttons, active-high, asynchronous to CLK_50
//   freq_num[LVL_W]         current frequency level
//   level_changed           one-cycle pulse when freq_num takes a new value
//   at_min, at_max          level at 0 / at MAX_LEVEL
//   dbUP, dbDN              debounced button levels
// Modports: master drives the buttons (board / bench); slave is the selector.
interface freq_select_if #(
   parameter int LVL_W = 3
);
   logic             pb_freq_up;
   logic             pb_freq_dn;
   logic [LVL_W-1:0] freq_num;
   logic             level_changed;
   logic             at_min;
   logic             at_max;
   logic             dbUP;
   logic             dbDN;

   modport master (
      output pb_freq_up, pb_freq_dn,
      input  freq_num, level_changed, at_min, at_max, dbUP, dbDN
   );

   modport slave (
      input  pb_freq_up, pb_freq_dn,
      output freq_num, level_changed, at_min, at_max, dbUP, dbDN
   );
endinterface

// File: rtl/freq_select_ctrl.sv
// rtl/freq_select_ctrl.sv - debounced up/down buttons with auto-repeat driving a saturating level
//
// Purpose: synchronises and debounces the up/down pushbuttons, runs a press/hold
//          auto-repeat FSM and keeps the saturating frequency level (0..MAX_LEVEL)
//          used by the throttle clock divider.
// Ports:
//   CLK_50  in  50 MHz system clock
//   reset   in  asynchronous, active-high reset
//   bus     freq_select_if.slave: pb_freq_up/pb_freq_dn in; freq_num, level_changed,
//           at_min, at_max, dbUP, dbDN out
module freq_select_ctrl #(
   parameter int DB_CYCLES    = 500000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 10000000,
   parameter int MAX_LEVEL    = 5,
   parameter int LVL_W        = 3
) (
   input  logic          CLK_50,
   input  logic          reset,
   freq_select_if.slave  bus
);
   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_DN   = 2'd2;

   // Bit 0 is the up button, bit 1 the down button throughout.
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            db_q, db_d;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [1:0]            state_q, state_d;
   logic [1:0]            dir_q, dir_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [LVL_W-1:0]      freq_num_q, freq_num_d;
   logic                  level_changed_q, level_changed_d;
   // Stored as "above minimum" so every flop clears on reset while at_min reads 1.
   logic                  above_min_q, above_min_d;
   logic                  at_max_q, at_max_d;

   logic [1:0]            dir;
   logic                  step;

   always_comb begin
      sync1_d = {bus.pb_freq_dn, bus.pb_freq_up};
      sync2_d = sync1_q;
      db_d    = db_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            // The flip happens on the edge where the count would reach DB_CYCLES.
            if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
               db_d[i] = ~db_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      case (db_q)
         2'b01:   dir = DIR_UP;
         2'b10:   dir = DIR_DN;
         default: dir = DIR_NONE;
      endcase

      step    = 1'b0;
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (dir != DIR_NONE) begin
               step    = 1'b1;
               dir_d   = dir;
               timer_d = TMR_W'(REPEAT_DELAY - 1);
               state_d = ST_ARMED;
            end
         end
         ST_ARMED, ST_REPEAT: begin
            // Any change of direction (including via "both pressed") abandons the hold.
            if (dir != dir_q) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_q == '0) begin
               step    = 1'b1;
               timer_d = TMR_W'(REPEAT_RATE - 1);
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase

      freq_num_d      = freq_num_q;
      level_changed_d = 1'b0;
      if (step) begin
         if (dir == DIR_UP && freq_num_q != LVL_W'(MAX_LEVEL)) begin
            freq_num_d      = freq_num_q + LVL_W'(1);
            level_changed_d = 1'b1;
         end else if (dir == DIR_DN && freq_num_q != '0) begin
            freq_num_d      = freq_num_q - LVL_W'(1);
            level_changed_d = 1'b1;
         end
      end
      // Flags are registered alongside freq_num so they never glitch between steps.
      above_min_d = (freq_num_d != '0);
      at_max_d    = (freq_num_d == LVL_W'(MAX_LEVEL));
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         sync1_q         <= '0;
         sync2_q         <= '0;
         db_q            <= '0;
         db_cnt_q        <= '0;
         state_q         <= ST_IDLE;
         dir_q           <= DIR_NONE;
         timer_q         <= '0;
         freq_num_q      <= '0;
         level_changed_q <= 1'b0;
         above_min_q     <= 1'b0;
         at_max_q        <= 1'b0;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         db_q            <= db_d;
         db_cnt_q        <= db_cnt_d;
         state_q         <= state_d;
         dir_q           <= dir_d;
         timer_q         <= timer_d;
         freq_num_q      <= freq_num_d;
         level_changed_q <= level_changed_d;
         above_min_q     <= above_min_d;
         at_max_q        <= at_max_d;
      end
   end

   assign bus.freq_num      = freq_num_q;
   assign bus.level_changed = level_changed_q;
   assign bus.at_min        = ~above_min_q;
   assign bus.at_max        = at_max_q;
   assign bus.dbUP          = db_q[0];
   assign bus.dbDN          = db_q[1];
endmodule

// File: tb/tb_freq_select_ctrl.sv
// tb/tb_freq_select_ctrl.sv - self-checking bench for freq_select_ctrl
module tb_freq_select_ctrl;
   localparam int DB   = 4;
   localparam int RD   = 20;
   localparam int RR   = 8;
   localparam int MAXL = 5;
   localparam int LW   = 3;

   typedef struct {
      int cyc;
      int lvl;
   } ev_t;

   logic CLK_50 = 1'b0;
   logic reset  = 1'b1;
   int   cyc    = 0;

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   up_rise;
   bit   dn_seen;
   bit   min_lost;
   int   first_step;

   always #10 CLK_50 = ~CLK_50;
   always @(posedge CLK_50) cyc <= cyc + 1;

   freq_select_if #(.LVL_W(LW)) bus ();

   freq_select_ctrl #(
      .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .MAX_LEVEL(MAXL), .LVL_W(LW)
   ) dut (
      .CLK_50(CLK_50),
      .reset (reset),
      .bus   (bus)
   );

   // Advances n clock cycles, sampling on falling edges and logging level_changed pulses.
   task automatic run(input int n);
      ev_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK_50);
         if (bus.level_changed) begin
            e.cyc = cyc;
            e.lvl = int'(bus.freq_num);
            obs_q.push_back(e);
         end
         if (bus.dbUP && up_rise < 0) up_rise = cyc;
         if (bus.dbDN) dn_seen = 1'b1;
         if (!bus.at_min) min_lost = 1'b1;
      end
   endtask

   task automatic push_exp(input int c, input int l);
      ev_t e;
      e.cyc = c;
      e.lvl = l;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      run(2);
      n_checks += 6;
      if (bus.freq_num !== 3'd0) begin n_fail++; $display("FAIL reset_freq: got %0d want 0", bus.freq_num); end
      if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.level_changed); end
      if (bus.dbUP !== 1'b0) begin n_fail++; $display("FAIL reset_dbUP: got %b want 0", bus.dbUP); end
      if (bus.dbDN !== 1'b0) begin n_fail++; $display("FAIL reset_dbDN: got %b want 0", bus.dbDN); end
      if (bus.at_min !== 1'b1) begin n_fail++; $display("FAIL reset_at_min: got %b want 1", bus.at_min); end
      if (bus.at_max !== 1'b0) begin n_fail++; $display("FAIL reset_at_max: got %b want 0", bus.at_max); end
      reset = 1'b0;
      run(3);
   endtask

   task automatic test_bounce_up();
      int last;
      ev_t e, o;
      obs_q.delete();
      up_rise = -1;
      for (int i = 0; i < 10; i++) begin
         bus.pb_freq_up = ~bus.pb_freq_up;
         run(2);
      end
      last = cyc;
      bus.pb_freq_up = 1'b1;
      first_step = last + DB + 3;
      push_exp(first_step, 1);
      run(10);
      n_checks++;
      if (up_rise !== last + DB + 2) begin
         n_fail++; $display("FAIL bounce_dbUP_rise: got cycle %0d want %0d", up_rise, last + DB + 2);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL bounce_step: no pulse, want level %0d at cycle %0d", e.lvl, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.lvl !== e.lvl) begin
               n_fail++; $display("FAIL bounce_step: got level %0d at %0d want %0d at %0d", o.lvl, o.cyc, e.lvl, e.cyc);
            end
         end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL bounce_extra: got %0d extra pulses want 0", obs_q.size()); end
   endtask

   task automatic test_hold_repeat();
      ev_t e, o;
      obs_q.delete();
      push_exp(first_step + RD, 2);
      push_exp(first_step + RD + RR, 3);
      push_exp(first_step + RD + 2 * RR, 4);
      push_exp(first_step + RD + 3 * RR, 5);
      run(first_step + RD + 4 * RR + 4 - cyc);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL repeat_step: no pulse, want level %0d at cycle %0d", e.lvl, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.lvl !== e.lvl) begin
               n_fail++; $display("FAIL repeat_step: got level %0d at %0d want %0d at %0d", o.lvl, o.cyc, e.lvl, e.cyc);
            end
         end
      end
      n_checks += 4;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL repeat_sat_pulse: got %0d extra pulses want 0", obs_q.size()); end
      if (bus.freq_num !== 3'd5) begin n_fail++; $display("FAIL repeat_freq: got %0d want 5", bus.freq_num); end
      if (bus.at_max !== 1'b1) begin n_fail++; $display("FAIL repeat_at_max: got %b want 1", bus.at_max); end
      if (bus.at_min !== 1'b0) begin n_fail++; $display("FAIL repeat_at_min: got %b want 0", bus.at_min); end
      bus.pb_freq_up = 1'b0;
      run(10);
   endtask

   task automatic test_floor_dn();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(2);
      obs_q.delete();
      dn_seen  = 1'b0;
      min_lost = 1'b0;
      bus.pb_freq_dn = 1'b1;
      run(40);
      n_checks += 4;
      if (dn_seen !== 1'b1) begin n_fail++; $display("FAIL floor_dbDN: got %b want 1", dn_seen); end
      if (min_lost !== 1'b0) begin n_fail++; $display("FAIL floor_at_min: got dropped=%b want 0", min_lost); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL floor_pulse: got %0d pulses want 0", obs_q.size()); end
      if (bus.freq_num !== 3'd0) begin n_fail++; $display("FAIL floor_freq: got %0d want 0", bus.freq_num); end
      bus.pb_freq_dn = 1'b0;
      run(10);
   endtask

   task automatic test_reversal();
      int u;
      ev_t e, o;
      obs_q.delete();
      u = cyc;
      bus.pb_freq_up = 1'b1;
      push_exp(u + DB + 3, 1);
      run(10);
      bus.pb_freq_dn = 1'b1;
      run(20);
      bus.pb_freq_up = 1'b0;
      push_exp(u + 30 + DB + 3, 0);
      run(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL reversal_step: no pulse, want level %0d at cycle %0d", e.lvl, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.lvl !== e.lvl) begin
               n_fail++; $display("FAIL reversal_step: got level %0d at %0d want %0d at %0d", o.lvl, o.cyc, e.lvl, e.cyc);
            end
         end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL reversal_extra: got %0d extra pulses want 0", obs_q.size()); end
      bus.pb_freq_dn = 1'b0;
      run(10);
   endtask

   task automatic test_reset_mid_repeat();
      int u, r;
      ev_t e, o;
      obs_q.delete();
      u = cyc;
      bus.pb_freq_up = 1'b1;
      push_exp(u + DB + 3, 1);
      push_exp(u + DB + 3 + RD, 2);
      push_exp(u + DB + 3 + RD + RR, 3);
      run(38);
      n_checks++;
      if (bus.freq_num !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_freq: got %0d want 3", bus.freq_num); end
      reset = 1'b1;
      #1;
      n_checks += 3;
      if (bus.freq_num !== 3'd0) begin n_fail++; $display("FAIL midrst_freq: got %0d want 0", bus.freq_num); end
      if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse: got %b want 0", bus.level_changed); end
      if (bus.dbUP !== 1'b0) begin n_fail++; $display("FAIL midrst_dbUP: got %b want 0", bus.dbUP); end
      run(3);
      reset = 1'b0;
      r = cyc;
      push_exp(r + DB + 3, 1);
      push_exp(r + DB + 3 + RD, 2);
      run(28);
      bus.pb_freq_up = 1'b0;
      run(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL midrst_step: no pulse, want level %0d at cycle %0d", e.lvl, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.lvl !== e.lvl) begin
               n_fail++; $display("FAIL midrst_step: got level %0d at %0d want %0d at %0d", o.lvl, o.cyc, e.lvl, e.cyc);
            end
         end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_extra: got %0d extra pulses want 0", obs_q.size()); end
   endtask

   task automatic test_glitch_dn();
      obs_q.delete();
      dn_seen = 1'b0;
      bus.pb_freq_dn = 1'b1;
      run(3);
      bus.pb_freq_dn = 1'b0;
      run(20);
      n_checks += 5;
      if (dn_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_dbDN: got rose=%b want 0", dn_seen); end
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulse: got %0d pulses want 0", obs_q.size()); end
      if (bus.freq_num !== 3'd2) begin n_fail++; $display("FAIL glitch_freq: got %0d want 2", bus.freq_num); end
      if (bus.at_min !== 1'b0) begin n_fail++; $display("FAIL glitch_at_min: got %b want 0", bus.at_min); end
      if (bus.at_max !== 1'b0) begin n_fail++; $display("FAIL glitch_at_max: got %b want 0", bus.at_max); end
   endtask

   initial begin
      bus.pb_freq_up = 1'b0;
      bus.pb_freq_dn = 1'b0;
      up_rise  = -1;
      dn_seen  = 1'b0;
      min_lost = 1'b0;
      test_reset();
      test_bounce_up();
      test_hold_repeat();
      test_floor_dn();
      test_reversal();
      test_reset_mid_repeat();
      test_glitch_dn();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
